// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational (zero latency); updates land on the clk_i rising edge; start_i clears asynchronously.
module btb_predictor #(
   parameter int ADDR_W  = 32,
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2,
   parameter int CNT_W   = 16
) (
   input  logic              clk_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] pc_i,
   output logic              hit_o,
   output logic              pred_taken_o,
   output logic [ADDR_W-1:0] npc_o,
   input  logic              upd_valid_i,
   input  logic [ADDR_W-1:0] upd_pc_i,
   input  logic              upd_taken_i,
   input  logic [ADDR_W-1:0] upd_target_i,
   input  logic              upd_pred_taken_i,
   input  logic [ADDR_W-1:0] upd_pred_target_i,
   input  logic              invalidate_i,
   output logic              mispredict_o,
   output logic [CNT_W-1:0]  mispred_cnt_o
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

   logic [ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [ADDR_W-1:0]  r_target [ENTRIES];
   logic [CTR_W-1:0]   r_ctr    [ENTRIES];
   logic [CNT_W-1:0]   r_mp_cnt;

   // Instructions are word aligned, so the two PC LSBs carry no information.
   logic w_unused_lsb;
   assign w_unused_lsb = ^{pc_i[1:0], upd_pc_i[1:0]};

   // Fetch-side lookup
   logic [IDX_W-1:0]  w_lk_idx;
   logic [TAG_W-1:0]  w_lk_tag;
   logic              w_lk_hit;
   logic              w_lk_taken;
   logic [ADDR_W-1:0] w_lk_seq;

   assign w_lk_idx   = pc_i[IDX_W+1:2];
   assign w_lk_tag   = pc_i[ADDR_W-1:IDX_W+2];
   assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
   assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][CTR_W-1];
   assign w_lk_seq   = pc_i + ADDR_W'(4);

   assign hit_o        = w_lk_hit;
   assign pred_taken_o = w_lk_taken;
   assign npc_o        = w_lk_taken ? r_target[w_lk_idx] : w_lk_seq;

   // Resolve-side update
   logic [IDX_W-1:0] w_up_idx;
   logic [TAG_W-1:0] w_up_tag;
   logic             w_up_hit;
   logic [CTR_W-1:0] w_ctr_cur;
   logic [CTR_W-1:0] w_ctr_inc;
   logic [CTR_W-1:0] w_ctr_dec;
   logic             w_dir_wrong;
   logic             w_tgt_wrong;

   assign w_up_idx  = upd_pc_i[IDX_W+1:2];
   assign w_up_tag  = upd_pc_i[ADDR_W-1:IDX_W+2];
   assign w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
   assign w_ctr_cur = r_ctr[w_up_idx];
   assign w_ctr_inc = (w_ctr_cur == CTR_MAX) ? w_ctr_cur : w_ctr_cur + CTR_W'(1);
   assign w_ctr_dec = (w_ctr_cur == '0)      ? w_ctr_cur : w_ctr_cur - CTR_W'(1);

   // A taken branch is only correct if the carried-down target also matched.
   assign w_dir_wrong  = upd_pred_taken_i != upd_taken_i;
   assign w_tgt_wrong  = upd_taken_i && (upd_target_i != upd_pred_target_i);
   assign mispredict_o = upd_valid_i && (w_dir_wrong || w_tgt_wrong);

   assign mispred_cnt_o = r_mp_cnt;

   always_ff @(posedge clk_i or negedge start_i) begin
      if (!start_i) begin
         r_valid  <= '0;
         r_mp_cnt <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= CTR_WNT;
         end
      end else begin
         if (mispredict_o && (r_mp_cnt != '1)) begin
            r_mp_cnt <= r_mp_cnt + CNT_W'(1);
         end
         // Invalidate wins over a same-cycle update; counters and targets are kept.
         if (invalidate_i) begin
            r_valid <= '0;
         end else if (upd_valid_i) begin
            if (w_up_hit) begin
               if (upd_taken_i) begin
                  r_ctr[w_up_idx]    <= w_ctr_inc;
                  r_target[w_up_idx] <= upd_target_i;
               end else begin
                  r_ctr[w_up_idx]    <= w_ctr_dec;
               end
            end else if (upd_taken_i) begin
               r_valid[w_up_idx]  <= 1'b1;
               r_tag[w_up_idx]    <= w_up_tag;
               r_target[w_up_idx] <= upd_target_i;
               r_ctr[w_up_idx]    <= CTR_WT;
            end
         end
      end
   end

endmodule
